// File: rtl/debounce_edge_n.sv
// debounce_edge_n: per-channel synchroniser, saturating debounce filter and registered rise/fall pulses
module debounce_edge_n #(
  parameter int N = 4,
  parameter int SYNC_STAGES = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] level_out,
  output logic [N-1:0] pulse_rise,
  output logic [N-1:0] pulse_fall,
  output logic         any_event
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d, s_out, flip, done;
  always_comb begin
    sync_d = sync_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    rise_d = '0;
    fall_d = '0;
    s_out = '0;
    flip = '0;
    done = '0;
    for (int i = 0; i < N; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], data_in[i]};
      s_out[i] = sync_q[i][SYNC_STAGES-1];
      flip[i] = s_out[i] != lvl_q[i];
      done[i] = flip[i] && cnt_q[i] == CMAX;
      // any return to the stable level restarts the count, so glitches never accumulate
      cnt_d[i] = (flip[i] && !done[i]) ? cnt_q[i] + 1'b1 : '0;
      lvl_d[i] = done[i] ? s_out[i] : lvl_q[i];
      rise_d[i] = done[i] & s_out[i];
      fall_d[i] = done[i] & ~s_out[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level_out = lvl_q;
  assign pulse_rise = rise_q;
  assign pulse_fall = fall_q;
  assign any_event = |{rise_q, fall_q};
endmodule

// File: tb/tb_debounce_edge_n.sv
// tb_debounce_edge_n: scoreboard bench; stimulus queues expected pulse events, monitors pop on any_event
module tb_debounce_edge_n;
  typedef struct {
    int cyc;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;
  logic clk = 0;
  logic reset, r2, done2 = 0;
  logic [3:0] data_in, level_out, pulse_rise, pulse_fall;
  logic any_event;
  logic [0:0] d2, l2, pr2, pf2;
  logic ae2;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  debounce_edge_n dut (
    .clk(clk), .reset(reset), .data_in(data_in), .level_out(level_out),
    .pulse_rise(pulse_rise), .pulse_fall(pulse_fall), .any_event(any_event)
  );
  debounce_edge_n #(.N(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk(clk), .reset(r2), .data_in(d2), .level_out(l2),
    .pulse_rise(pr2), .pulse_fall(pf2), .any_event(ae2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect1(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r, input logic [3:0] f);
    data_in = v;
    q1.push_back('{cyc + 19, l, r, f});
  endtask
  // event packs as {cycle, level, rise, fall} so a late/early pulse shows in the cycle field
  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      e1 = q1.pop_front();
      chk("missing_event1", 64'(cyc), 64'(e1.cyc));
    end
    if (any_event) begin
      if (q1.size() == 0) chk("unexpected_event1", {cyc, level_out, pulse_rise, pulse_fall}, 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("event1", {cyc, level_out, pulse_rise, pulse_fall}, {e1.cyc, e1.lvl, e1.rise, e1.fall});
      end
    end
  end
  always @(negedge clk) begin
    while (q2.size() > 0 && q2[0].cyc < cyc) begin
      e2 = q2.pop_front();
      chk("missing_event2", 64'(cyc), 64'(e2.cyc));
    end
    if (ae2) begin
      if (q2.size() == 0) chk("unexpected_event2", {cyc, 4'(l2), 4'(pr2), 4'(pf2)}, 64'd0);
      else begin
        e2 = q2.pop_front();
        chk("event2", {cyc, 4'(l2), 4'(pr2), 4'(pf2)}, {e2.cyc, e2.lvl, e2.rise, e2.fall});
      end
    end
  end
  initial begin
    r2 = 1;
    d2 = 0;
    wait_n(2);
    r2 = 0;
    for (int i = 0; i < 20; i++) begin
      d2 = ~d2;
      q2.push_back('{cyc + 3, {3'b0, d2}, {3'b0, d2}, {3'b0, ~d2}});
      wait_n(1);
    end
    wait_n(6);
    done2 = 1;
  end
  initial begin
    reset = 1;
    data_in = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {level_out, pulse_rise, pulse_fall, any_event}, 64'd0);
    end
    reset = 0;
    q1.push_back('{cyc + 19, 4'hF, 4'hF, 4'h0});
    wait_n(25);
    expect1(4'hE, 4'hE, 4'h0, 4'h1);
    wait_n(25);
    expect1(4'hF, 4'hF, 4'h1, 4'h0);
    wait_n(25);
    expect1(4'hD, 4'hD, 4'h0, 4'h2);
    wait_n(25);
    data_in = 4'hF;
    wait_n(5);
    data_in = 4'hD;
    wait_n(3);
    data_in = 4'hF;
    wait_n(10);
    data_in = 4'hD;
    wait_n(25);
    chk("bounce_level", 64'(level_out), 64'hD);
    expect1(4'h9, 4'h9, 4'h0, 4'h4);
    wait_n(25);
    expect1(4'h5, 4'h5, 4'h4, 4'h8);
    wait_n(25);
    expect1(4'h4, 4'h4, 4'h0, 4'h1);
    wait_n(25);
    data_in = 4'h5;
    wait_n(10);
    reset = 1;
    wait_n(1);
    chk("midreset_outputs", {level_out, pulse_rise, pulse_fall}, 64'd0);
    reset = 0;
    q1.push_back('{cyc + 19, 4'h5, 4'h5, 4'h0});
    wait_n(25);
    wait (done2);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
